// File: rtl/dnn_out_argmax.sv
// Output stage: captures N_CLASSES signed scores on eng_done rising edge, scans for argmax one compare per cycle.
// Optional DNN_OUT_ONEHOT_EN adds a one-hot class vector output.
module dnn_out_argmax #(
  parameter int N_CLASSES  = 10,
  parameter int DATA_WIDTH = 2,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_eng_done,
  input  logic signed [DATA_WIDTH-1:0] i_eng_out [N_CLASSES-1:0],
  input  logic                         i_clear,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic        [IDX_WIDTH-1:0]  o_class_idx,
  output logic signed [DATA_WIDTH-1:0] o_class_score,
  output logic                         o_tie,
`ifdef DNN_OUT_ONEHOT_EN
  output logic        [N_CLASSES-1:0]  o_class_onehot,
`endif
  input  logic        [IDX_WIDTH-1:0]  i_rd_idx,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);

  state_t                      r_state;
  state_t                      w_next_state;
  logic                        r_done_q;
  logic signed [DATA_WIDTH-1:0] r_bank [N_CLASSES-1:0];
  logic signed [DATA_WIDTH-1:0] r_best;
  logic        [IDX_WIDTH-1:0]  r_best_idx;
  logic                         r_tie;
  logic        [IDX_WIDTH-1:0]  r_scan_idx;
  logic signed [DATA_WIDTH-1:0] r_rd_data;

  logic                         w_cap_evt;
  logic                         w_cap_ok;
  logic                         w_scanning;
  logic signed [DATA_WIDTH-1:0] w_scan_val;
  logic signed [DATA_WIDTH-1:0] w_rd_val;

  assign w_cap_evt  = i_eng_done & ~r_done_q;
  // Captures arriving mid-scan are dropped, and clear beats a same-cycle capture.
  assign w_cap_ok   = w_cap_evt & ~i_clear & (r_state != SCAN);
  assign w_scanning = (r_state == SCAN) & ~i_clear;

  // Explicit mux loops keep out-of-range indices mapped to entry 0.
  always_comb begin
    w_scan_val = r_bank[0];
    for (int unsigned i = 0; i < N_CLASSES; i++) begin
      if (r_scan_idx == IDX_WIDTH'(i)) w_scan_val = r_bank[i];
    end
  end

  always_comb begin
    w_rd_val = r_bank[0];
    for (int unsigned i = 0; i < N_CLASSES; i++) begin
      if (i_rd_idx == IDX_WIDTH'(i)) w_rd_val = r_bank[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_cap_evt) begin
            if (N_CLASSES == 1) w_next_state = DONE;
            else                w_next_state = SCAN;
          end
        end
        SCAN: begin
          if (r_scan_idx == LAST_IDX) w_next_state = DONE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done_q   <= 1'b0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_tie      <= 1'b0;
      r_scan_idx <= '0;
      r_rd_data  <= '0;
      for (int unsigned i = 0; i < N_CLASSES; i++) r_bank[i] <= '0;
    end else begin
      r_done_q  <= i_eng_done;
      r_rd_data <= w_rd_val;
      if (w_cap_ok) begin
        for (int unsigned i = 0; i < N_CLASSES; i++) r_bank[i] <= i_eng_out[i];
        r_best     <= i_eng_out[0];
        r_best_idx <= '0;
        r_tie      <= 1'b0;
        r_scan_idx <= IDX_WIDTH'(1);
      end else if (w_scanning) begin
        if (w_scan_val > r_best) begin
          r_best     <= w_scan_val;
          r_best_idx <= r_scan_idx;
          r_tie      <= 1'b0;
        end else if (w_scan_val == r_best) begin
          r_tie <= 1'b1;
        end
        if (r_scan_idx != LAST_IDX) r_scan_idx <= r_scan_idx + IDX_WIDTH'(1);
      end
    end
  end

  assign o_busy        = (r_state == SCAN);
  assign o_valid       = (r_state == DONE);
  assign o_class_idx   = r_best_idx;
  assign o_class_score = r_best;
  assign o_tie         = r_tie;
  assign o_rd_data     = r_rd_data;

`ifdef DNN_OUT_ONEHOT_EN
  always_comb begin
    o_class_onehot = '0;
    if (r_state == DONE) begin
      for (int unsigned i = 0; i < N_CLASSES; i++) begin
        if (r_best_idx == IDX_WIDTH'(i)) o_class_onehot[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/dnn_out_argmax.md
# dnn_out_argmax

Parametrised output stage for the MNIST inference engine. It snapshots the engine's N_CLASSES signed scores on the rising edge of the engine's done signal. It then runs a sequential, one-compare-per-cycle argmax scan to produce the classified digit and a tie flag. The captured scores stay readable through a registered, indexed read port. It sits between the dnn_* core and the board/test wrapper, and replaces the purely combinational 10-way output mux.

## Interface
- N_CLASSES, 10, number of engine outputs (≥1)
- DATA_WIDTH, 2, signed score width
- IDX_WIDTH, 4, width of class/read indices; must satisfy 2^IDX_WIDTH ≥ N_CLASSES

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- eng_done  in  1  engine done level; a 0→1 transition requests capture
- eng_out  in  N_CLASSES×DATA_WIDTH  signed engine scores, unpacked array [N_CLASSES-1:0]
- clear  in  1  synchronous drop of result, return to IDLE
- busy  out  1  high while capture/scan in progress
- valid  out  1  class_idx/class_score/tie are valid
- class_idx  out  IDX_WIDTH  index of maximum score
- class_score  out  DATA_WIDTH  signed maximum score
- tie  out  1  another index equals the maximum
- rd_idx  in  IDX_WIDTH  score read index
- rd_data  out  DATA_WIDTH  signed captured score at rd_idx

## Operation
- States:
  - IDLE: valid=0, busy=0.
  - SCAN: busy=1.
  - DONE: valid=1.
- done_q register holds eng_done delayed one cycle. Capture event = eng_done & ~done_q.
- Capture event in IDLE or DONE (and clear=0):
  - bank ← eng_out; best ← eng_out[0]; best_idx ← 0; tie ← 0; scan_idx ← 1; valid ← 0.
  - Next state is SCAN, or DONE directly if N_CLASSES==1.
- SCAN, each cycle, compares bank[scan_idx] against best, signed:
  - Strictly greater: best ← bank[scan_idx], best_idx ← scan_idx, tie ← 0.
  - Equal: tie ← 1.
  - Less: no change.
  - When scan_idx==N_CLASSES-1, go to DONE; otherwise scan_idx++.
- Ties resolve to the lowest index; the tie flag reports them.
- Capture event during SCAN is ignored; no queuing.
- clear=1 in any state → IDLE, valid=0. Clear wins over a same-cycle capture, and that capture is lost. done_q still updates.
- bank is not cleared by clear; it holds until the next capture.
- rd_data ← bank[rd_idx] every cycle. rd_idx ≥ N_CLASSES returns bank[0].

## Timing
- Reset values:
  - busy=0, valid=0, class_idx=0, class_score=0, tie=0, rd_data=0.
  - bank all 0, done_q=0, state IDLE.
- Capture sampled at edge k.
  - busy=1 after edge k.
  - valid=1 after edge k+N_CLASSES-1, i.e. 9 cycles for N_CLASSES=10.
  - busy=0 coincident with valid=1.
- class_idx/class_score/tie are driven from best/best_idx/tie registers. They are stable whenever valid=1 and hold until the next capture edge or clear.
- rd_data has 1-cycle latency; it reflects the new bank from edge k+1 onward.
- eng_done held high produces exactly one capture. A re-capture needs eng_done low for ≥1 cycle.
- rst mid-SCAN: all state returns to reset values at that edge; a partial result is never flagged valid.

## Configuration
- DNN_OUT_ONEHOT_EN defined:
  - Adds output class_onehot, N_CLASSES wide.
  - Bit class_idx is set when valid=1; the vector is all zeros when valid=0.
  - Registered with the same timing as valid.
- DNN_OUT_ONEHOT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then scores {0,0,1,0,-1,0,0,0,0,0}, eng_done 0→1 at edge k → busy after k; valid, class_idx=2, class_score=1, tie=0 after edge k+9.
- Scores {-1,1,-2,1,0,0,0,0,0,1} → class_idx=1, class_score=1, tie=1. All scores -2 → class_idx=0, tie=1.
- After valid, sweep rd_idx 0..15 → rd_data equals captured score one cycle later. rd_idx 10..15 return bank[0]. Changing eng_out without a capture leaves rd_data unchanged.
- Second 0→1 of eng_done at scan cycle 4 → ignored; result matches first capture. eng_done held high for 50 cycles → exactly one scan. Toggle low then high while in DONE → valid drops and a new result arrives 9 cycles later.
- clear asserted on the same edge as a capture event → IDLE, valid=0, no scan. rst at scan cycle 5 → all outputs 0, valid never asserts.
- With DNN_OUT_ONEHOT_EN, scores peaking at index 7 → class_onehot=10'b0010000000 while valid; 0 after clear.
